// File: rtl/camac_cycle_arbiter.sv
// camac_cycle_arbiter: shares one CAMAC cycle engine between the ISA host
// (port 0) and the LAM/auto-poll engine (port 1).
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   req0/a0/w0         host request (level), sub-address, direction (1=write)
//   req1/a1/w1         LAM engine request, sub-address, direction
//   grant0/grant1      port owns the automate from SETUP through DONE
//   done0/done1        one-cycle completion pulse for the owning port
//   err                valid with done*: cycle aborted by timeout
//   q_resp/x_resp      x0/x1 captured when rdy is seen in STROBE
//   a/w/sel            latched address/direction and strobe to the automate
//   rdy                cycle-complete from the automate
//   x0/x1              Q/X responses from the automate
//   busy               arbiter is not idle
module camac_cycle_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8,
    parameter bit HOST_PRIORITY  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [1:0] a0,
    input  logic       w0,
    input  logic       req1,
    input  logic [1:0] a1,
    input  logic       w1,
    output logic       grant0,
    output logic       grant1,
    output logic       done0,
    output logic       done1,
    output logic       err,
    output logic       q_resp,
    output logic       x_resp,
    output logic [1:0] a,
    output logic       w,
    output logic       sel,
    input  logic       rdy,
    input  logic       x0,
    input  logic       x1,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        RELEASE,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             owner_q;
    logic             last_q;
    logic [1:0]       a_q;
    logic             w_q;
    logic             q_q;
    logic             x_q;
    logic             err_q;

    logic             win_vld;
    logic             win;
    logic             cap;
    logic             err_set;
    logic             tmo;

    assign tmo = (cnt_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        win_vld = 1'b0;
        win     = 1'b0;
        cap     = 1'b0;
        err_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    win_vld = 1'b1;
                    if (req0 && req1)
                        // On a tie, round-robin hands it to whoever did not win last.
                        win = HOST_PRIORITY ? 1'b0 : ~last_q;
                    else
                        win = req1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = STROBE;
            end
            STROBE: begin
                // rdy already high on entry still counts as completion.
                if (rdy) begin
                    cap     = 1'b1;
                    state_d = RELEASE;
                end else if (tmo) begin
                    err_set = 1'b1;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!rdy) begin
                    state_d = DONE;
                end else if (tmo) begin
                    err_set = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            a_q     <= 2'b00;
            w_q     <= 1'b0;
            q_q     <= 1'b0;
            x_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            // Counter restarts on every state change and saturates at the limit.
            if (state_d != state_q)
                cnt_q <= '0;
            else if (!tmo)
                cnt_q <= cnt_q + CNT_W'(1);
            if (win_vld) begin
                owner_q <= win;
                last_q  <= win;
                a_q     <= win ? a1 : a0;
                w_q     <= win ? w1 : w0;
            end
            if (cap) begin
                q_q <= x0;
                x_q <= x1;
            end
            if (err_set)
                err_q <= 1'b1;
            else if (state_q == DONE)
                err_q <= 1'b0;
        end
    end

    assign busy   = (state_q != IDLE);
    assign grant0 = busy & ~owner_q;
    assign grant1 = busy & owner_q;
    assign done0  = (state_q == DONE) & ~owner_q;
    assign done1  = (state_q == DONE) & owner_q;
    assign err    = (state_q == DONE) & err_q;
    assign sel    = (state_q == STROBE);
    assign a      = a_q;
    assign w      = w_q;
    assign q_resp = q_q;
    assign x_resp = x_q;

endmodule

// File: tb/tb_camac_cycle_arbiter.sv
// tb_camac_cycle_arbiter: directed checks of arbitration, handshake,
// timeout, reset abort and address hold for camac_cycle_arbiter.
module tb_camac_cycle_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, w0, req1, w1, x0, x1;
    logic [1:0] a0, a1;
    logic       rdy;
    logic       auto_en, rdy_man, rdy_auto;

    logic       grant0, grant1, done0, done1, err, q_resp, x_resp, w, sel, busy;
    logic [1:0] a;
    logic       h_grant0, h_grant1, h_done0, h_done1, h_err, h_q, h_x, h_w;
    logic       h_sel, h_busy;
    logic [1:0] h_a;

    int total = 0;
    int bad   = 0;
    int n;
    int selcnt;

    always #5 clk = ~clk;

    // Simple automate model: answers one cycle after sel, drops with sel.
    always @(posedge clk) begin
        if (reset)
            rdy_auto <= 1'b0;
        else
            rdy_auto <= sel;
    end

    assign rdy = auto_en ? rdy_auto : rdy_man;

    camac_cycle_arbiter #(
        .TIMEOUT_CYCLES(8),
        .CNT_W(4),
        .HOST_PRIORITY(1'b0)
    ) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .a0(a0), .w0(w0),
        .req1(req1), .a1(a1), .w1(w1),
        .grant0(grant0), .grant1(grant1),
        .done0(done0), .done1(done1), .err(err),
        .q_resp(q_resp), .x_resp(x_resp),
        .a(a), .w(w), .sel(sel), .rdy(rdy),
        .x0(x0), .x1(x1), .busy(busy)
    );

    camac_cycle_arbiter #(
        .TIMEOUT_CYCLES(8),
        .CNT_W(4),
        .HOST_PRIORITY(1'b1)
    ) dut_hp (
        .clk(clk), .reset(reset),
        .req0(req0), .a0(a0), .w0(w0),
        .req1(req1), .a1(a1), .w1(w1),
        .grant0(h_grant0), .grant1(h_grant1),
        .done0(h_done0), .done1(h_done1), .err(h_err),
        .q_resp(h_q), .x_resp(h_x),
        .a(h_a), .w(h_w), .sel(h_sel), .rdy(rdy),
        .x0(x0), .x1(x1), .busy(h_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset   = 1'b1;
        req0    = 1'b1;
        a0      = 2'd2;
        w0      = 1'b1;
        req1    = 1'b0;
        a1      = 2'd0;
        w1      = 1'b0;
        x0      = 1'b0;
        x1      = 1'b0;
        auto_en = 1'b0;
        rdy_man = 1'b0;

        // 1: reset held 5 clocks with req0 high
        repeat (5) step();
        chk("rst_outs", 8'({grant0, grant1, done0, done1, err, sel, busy, q_resp}), 8'h00);
        chk("rst_aw", 8'({x_resp, w, a}), 8'h00);
        reset = 1'b0;
        step();
        chk("rel_grant", 8'({grant0, grant1, sel}), 8'b100);
        chk("rel_aw", 8'({w, a}), 8'h06);
        req0 = 1'b0;
        step();
        chk("rel_sel", 8'(sel), 8'h01);

        // 2: rdy three cycles after sel, low two cycles after that
        repeat (3) step();
        chk("wait_sel", 8'({sel, done0}), 8'b10);
        rdy_man = 1'b1;
        x0 = 1'b1;
        x1 = 1'b0;
        step();
        chk("rdy_seen", 8'({sel, q_resp, x_resp}), 8'b010);
        step();
        chk("release_hold", 8'({done0, busy}), 8'b01);
        rdy_man = 1'b0;
        x0 = 1'b0;
        step();
        chk("done0", 8'({done0, done1, err, grant0}), 8'b1001);
        chk("done_aw", 8'({w, a}), 8'h06);
        step();
        chk("done_pulse", 8'({done0, grant0, busy}), 8'b000);
        chk("resp_hold", 8'({q_resp, x_resp}), 8'b10);

        // 3: both requesters held continuously
        reset = 1'b1;
        auto_en = 1'b1;
        req0 = 1'b1;
        req1 = 1'b1;
        a0 = 2'd1;
        w0 = 1'b0;
        a1 = 2'd3;
        w1 = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!(done0 || done1) && n < 30) begin
                step();
                n++;
            end
            chk($sformatf("rr%0d_bound", i), 8'(n < 30), 8'h01);
            chk($sformatf("rr%0d_port", i), 8'({done1, done0}),
                (i % 2 == 1) ? 8'b10 : 8'b01);
            chk($sformatf("rr%0d_aw", i), 8'({w, a}),
                (i % 2 == 1) ? 8'h07 : 8'h01);
            chk($sformatf("hp%0d_port", i), 8'({h_done1, h_done0, h_a}), 8'b0101);
            if (i == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            step();
        end
        chk("rr_idle", 8'({busy, h_busy}), 8'b00);

        // 4: automate never answers
        auto_en = 1'b0;
        rdy_man = 1'b0;
        req0 = 1'b1;
        a0 = 2'd0;
        step();
        chk("to_grant", 8'(grant0), 8'h01);
        req0 = 1'b0;
        n = 0;
        selcnt = 0;
        while (!done0 && n < 30) begin
            step();
            n++;
            if (sel)
                selcnt++;
        end
        chk("to_bound", 8'(n < 30), 8'h01);
        chk("to_selcnt", 8'(selcnt), 8'd8);
        chk("to_err", 8'({err, h_err}), 8'b11);
        step();
        chk("to_err_clr", 8'({err, done0, busy}), 8'b000);

        // 5: reset during STROBE
        req1 = 1'b1;
        a1 = 2'd2;
        w1 = 1'b1;
        step();
        chk("r5_grant", 8'({grant1, w, a}), 8'b1110);
        req1 = 1'b0;
        step();
        chk("r5_sel", 8'(sel), 8'h01);
        reset = 1'b1;
        step();
        chk("r5_abort", 8'({sel, grant1, busy, done1, err}), 8'h00);
        reset = 1'b0;
        repeat (3) step();
        chk("r5_nodone", 8'({done0, done1, busy}), 8'h00);
        auto_en = 1'b1;
        req0 = 1'b1;
        a0 = 2'd3;
        w0 = 1'b0;
        step();
        chk("r5_regrant", 8'(grant0), 8'h01);
        req0 = 1'b0;
        n = 0;
        while (!done0 && n < 30) begin
            step();
            n++;
        end
        chk("r5_done", 8'({done0, err, a}), 8'b1011);
        step();

        // 6: host changes a0/w0 while granted
        req0 = 1'b1;
        a0 = 2'd1;
        w0 = 1'b0;
        step();
        chk("hold_grant", 8'({grant0, w, a}), 8'b1001);
        req0 = 1'b0;
        n = 0;
        while (!done0 && n < 30) begin
            a0 = a0 + 2'd1;
            w0 = ~w0;
            step();
            n++;
            chk("hold_aw", 8'({w, a}), 8'h01);
        end
        chk("hold_bound", 8'({done0, err}), 8'b10);
        step();
        chk("hold_idle", 8'(busy), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
